// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: blanking code,
// active-low hex digit codes (bit 7 = dp, bits 6:0 = g..a) and scan states.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] HEX_0 = 8'hC0;
    localparam logic [7:0] HEX_1 = 8'hF9;
    localparam logic [7:0] HEX_2 = 8'hA4;
    localparam logic [7:0] HEX_3 = 8'hB0;
    localparam logic [7:0] HEX_4 = 8'h99;
    localparam logic [7:0] HEX_5 = 8'h92;
    localparam logic [7:0] HEX_6 = 8'h82;
    localparam logic [7:0] HEX_7 = 8'hF8;
    localparam logic [7:0] HEX_8 = 8'h80;
    localparam logic [7:0] HEX_9 = 8'h98;
    localparam logic [7:0] HEX_A = 8'h88;
    localparam logic [7:0] HEX_B = 8'h83;
    localparam logic [7:0] HEX_C = 8'hC6;
    localparam logic [7:0] HEX_D = 8'hA1;
    localparam logic [7:0] HEX_E = 8'h86;
    localparam logic [7:0] HEX_F = 8'h8E;

    // BLANK: all segments and anodes off; DRIVE: one digit lit.
    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl_hexenc.sv
// 4-bit hex to active-low 7-segment encoder. The dp bit (bit 7) is always
// returned off; the caller merges the decimal point.
module hexEncode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] seg_o
);

    // Pure lookup from nibble to segment pattern.
    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_o = HEX_0;
            4'h1: seg_o = HEX_1;
            4'h2: seg_o = HEX_2;
            4'h3: seg_o = HEX_3;
            4'h4: seg_o = HEX_4;
            4'h5: seg_o = HEX_5;
            4'h6: seg_o = HEX_6;
            4'h7: seg_o = HEX_7;
            4'h8: seg_o = HEX_8;
            4'h9: seg_o = HEX_9;
            4'hA: seg_o = HEX_A;
            4'hB: seg_o = HEX_B;
            4'hC: seg_o = HEX_C;
            4'hD: seg_o = HEX_D;
            4'hE: seg_o = HEX_E;
            4'hF: seg_o = HEX_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. One digit is driven at a time, separated by an all-off blanking
// gap. New values are shadowed and only become active when the scan wraps
// from the last digit back to digit 0, so a frame never mixes old and new.
//
// Load handshake: load is a single-cycle request that captures value/dp_in
// into the shadow and marks it pending; a later load before the commit
// overwrites the shadow. At the frame wrap a pending shadow is copied to the
// active value and load_ack pulses for one cycle. A load on the wrap cycle
// itself stays pending for the following frame.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    load_ack,
    output logic                    frame_start,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES)
                           ? ((DIGIT_CYCLES > 2) ? DIGIT_CYCLES : 2)
                           : ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic             NO_BLANK   = (BLANK_CYCLES == 0);

    scan_state_e                 state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        first_q;

    logic [4*NUM_DIGITS-1:0]     act_q, act_d;
    logic [NUM_DIGITS-1:0]       act_dp_q, act_dp_d;
    logic [4*NUM_DIGITS-1:0]     sh_q;
    logic [NUM_DIGITS-1:0]       sh_dp_q;
    logic                        pend_q;

    logic                        wrap;
    logic                        commit;
    logic [3:0]                  nibble;
    logic [7:0]                  enc_seg;
    logic [7:0]                  seg_d;
    logic [NUM_DIGITS-1:0]       an_d;

    logic [7:0]                  seg_q;
    logic [NUM_DIGITS-1:0]       an_q;
    logic                        load_ack_q;
    logic                        frame_start_q;

    // Next scan position; outputs are computed from the post-edge state so
    // seg/an change on the same edge the state does.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        wrap    = 1'b0;
        case (state_q)
            BLANK: begin
                if (NO_BLANK || cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == DIGIT_LAST) begin
                    cnt_d   = '0;
                    state_d = NO_BLANK ? DRIVE : BLANK;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = BLANK;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Commit the shadow at the frame wrap and select the digit to display.
    always_comb begin
        commit   = wrap & pend_q;
        act_d    = commit ? sh_q    : act_q;
        act_dp_d = commit ? sh_dp_q : act_dp_q;
        nibble   = act_d[{idx_d, 2'b00} +: 4];
    end

    hexEncode u_hex (
        .nibble_i (nibble),
        .seg_o    (enc_seg)
    );

    // dp merge and anode select for the upcoming cycle; dig_en is sampled live.
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        if (state_d == DRIVE && dig_en[idx_d]) begin
            seg_d = {enc_seg[7] & ~act_dp_d[idx_d], enc_seg[6:0]};
            an_d  = ~(NUM_DIGITS'(1) << idx_d);
        end
    end

    // Scan FSM with registered display outputs and frame/ack pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BLANK;
            idx_q         <= '0;
            cnt_q         <= '0;
            first_q       <= 1'b1;
            seg_q         <= SEG_BLANK;
            an_q          <= '1;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            first_q       <= 1'b0;
            seg_q         <= seg_d;
            an_q          <= an_d;
            load_ack_q    <= commit;
            frame_start_q <= wrap | first_q;
        end
    end

    // Shadow capture on load and active update on commit; newest load wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q    <= '0;
            act_dp_q <= '0;
            sh_q     <= '0;
            sh_dp_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            act_q    <= act_d;
            act_dp_q <= act_dp_d;
            if (load) begin
                sh_q    <= value;
                sh_dp_q <= dp_in;
                pend_q  <= 1'b1;
            end else if (commit) begin
                pend_q  <= 1'b0;
            end
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with NUM_DIGITS=4, DIGIT_CYCLES=4, BLANK_CYCLES=2.
// The reference model tracks the cycle number since reset release and
// derives slot/phase from it with plain arithmetic.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int DC    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = DC + BC;
    localparam int FRAME = N * SLOT;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [4*N-1:0] value;
    logic [N-1:0]  dp_in;
    logic [N-1:0]  dig_en;
    logic          load_ack;
    logic          frame_start;
    logic [7:0]    seg;
    logic [N-1:0]  an;

    int checks;
    int failures;

    // model state
    int            t;
    logic [15:0]   m_act, m_sh;
    logic [3:0]    m_act_dp, m_sh_dp, m_en;
    logic          m_pend, m_ack, m_fs;
    logic [7:0]    hex_tab [16];

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .dig_en      (dig_en),
        .load_ack    (load_ack),
        .frame_start (frame_start),
        .seg         (seg),
        .an          (an)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
        end
    endtask

    task automatic model_reset();
        t        = 0;
        m_act    = '0;
        m_sh     = '0;
        m_act_dp = '0;
        m_sh_dp  = '0;
        m_en     = '1;
        m_pend   = 1'b0;
        m_ack    = 1'b0;
        m_fs     = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs present at it.
    task automatic model_edge();
        bit wrap;
        wrap  = ((t % FRAME) == FRAME - 1);
        m_ack = wrap && m_pend;
        if (m_ack) begin
            m_act    = m_sh;
            m_act_dp = m_sh_dp;
            m_pend   = 1'b0;
        end
        if (load) begin
            m_sh    = value;
            m_sh_dp = dp_in;
            m_pend  = 1'b1;
        end
        m_en = dig_en;
        m_fs = (t == 0) || wrap;
        t++;
    endtask

    task automatic check_outputs();
        int p, slot, w;
        logic [7:0] es;
        logic [3:0] ea;
        p    = t % FRAME;
        slot = p / SLOT;
        w    = p % SLOT;
        if (w < BC || !m_en[slot]) begin
            es = 8'hFF;
            ea = 4'hF;
        end else begin
            es = hex_tab[m_act[slot*4 +: 4]];
            if (m_act_dp[slot]) es[7] = 1'b0;
            ea = 4'hF & ~(4'b0001 << slot);
        end
        chk("seg", 32'(seg), 32'(es));
        chk("an", 32'(an), 32'(ea));
        chk("load_ack", 32'(load_ack), 32'(m_ack));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        value = v;
        dp_in = dp;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        model_reset();
        check_outputs();
    endtask

    int ack_cnt;

    initial begin
        hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = '0;
        dp_in    = '0;
        dig_en   = '1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(seg), 32'h0FF);
        chk("rst_an", 32'(an), 32'hF);

        // Reset release: blank, then digit 0 showing 0
        release_reset();
        chk("p1_fs_t0", 32'(frame_start), 32'd0);
        tick();
        chk("p1_fs_t1", 32'(frame_start), 32'd1);
        chk("p1_an_t1", 32'(an), 32'hF);
        tick();
        chk("p1_an_t2", 32'(an), 32'hE);
        chk("p1_seg_t2", 32'(seg), 32'hC0);
        run_to(5);
        chk("p1_seg_t5", 32'(seg), 32'hC0);
        run_to(6);
        chk("p1_an_t6", 32'(an), 32'hF);

        // Mid-frame load of 1234
        run_to(8);
        do_load(16'h1234, 4'b0000);
        run_to(24);
        chk("p2_ack", 32'(load_ack), 32'd1);
        run_to(26); chk("p2_d0", 32'({an, seg}), 32'h0E99);
        run_to(32); chk("p2_d1", 32'({an, seg}), 32'h0DB0);
        run_to(38); chk("p2_d2", 32'({an, seg}), 32'h0BA4);
        run_to(44); chk("p2_d3", 32'({an, seg}), 32'h07F9);

        // Two loads in one frame: newest wins, one ack
        run_to(50);
        do_load(16'h00AB, 4'b0000);
        run_to(55);
        do_load(16'hCDEF, 4'b0000);
        ack_cnt = 0;
        while (t < 73) begin
            tick();
            ack_cnt += int'(load_ack);
        end
        chk("p3_ack_cnt", 32'(ack_cnt), 32'd1);
        run_to(74); chk("p3_d0", 32'(seg), 32'h8E);
        run_to(80); chk("p3_d1", 32'(seg), 32'h86);
        run_to(86); chk("p3_d2", 32'(seg), 32'hA1);
        run_to(92); chk("p3_d3", 32'(seg), 32'hC6);

        // Decimal point merge
        run_to(100);
        do_load(16'h0008, 4'b0010);
        run_to(122); chk("p4_d0", 32'(seg), 32'h80);
        run_to(128); chk("p4_d1", 32'(seg), 32'h40);
        run_to(134); chk("p4_d2", 32'(seg), 32'hC0);
        run_to(140); chk("p4_d3", 32'(seg), 32'hC0);

        // Digit enables
        run_to(143);
        dig_en = 4'b0101;
        run_to(146); chk("p5_d0", 32'({an, seg}), 32'h0E80);
        run_to(152); chk("p5_d1", 32'({an, seg}), 32'h0FFF);
        run_to(158); chk("p5_d2", 32'({an, seg}), 32'h0BC0);
        run_to(164); chk("p5_d3", 32'({an, seg}), 32'h0FFF);
        run_to(168); chk("p5_fs", 32'(frame_start), 32'd1);
        dig_en = 4'b1111;

        // Async reset mid idx-2 drive with a pending load
        run_to(170);
        do_load(16'h5555, 4'b1111);
        run_to(182);
        #2 rst_n = 1'b0;
        #1;
        chk("p6_async_an", 32'(an), 32'hF);
        chk("p6_async_seg", 32'(seg), 32'hFF);
        chk("p6_async_fs", 32'(frame_start), 32'd0);
        repeat (2) @(negedge clk);
        release_reset();
        run_to(2);  chk("p6_seg_t2", 32'(seg), 32'hC0);
        run_to(24); chk("p6_no_ack", 32'(load_ack), 32'd0);

        // Load on the commit cycle stays pending for the next frame
        run_to(34);
        do_load(16'h0001, 4'b0000);
        run_to(47);
        do_load(16'h0002, 4'b0000);
        chk("p7_ack1", 32'(load_ack), 32'd1);
        run_to(50); chk("p7_d0a", 32'(seg), 32'hF9);
        run_to(72); chk("p7_ack2", 32'(load_ack), 32'd1);
        run_to(74); chk("p7_d0b", 32'(seg), 32'hA4);

        // Randomized traffic
        repeat (800) begin
            if ($urandom_range(0, 7) == 0) begin
                value = 16'($urandom);
                dp_in = 4'($urandom);
                load  = 1'b1;
            end else begin
                load  = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) dig_en = 4'($urandom);
            tick();
        end
        load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
